// File: rtl/sprite_fetch_sequencer.sv
// sprite_fetch_sequencer
// Walks every pixel of one animation frame, drives the sprite ROM address,
// re-aligns the 2-cycle ROM read data with pixel coordinates and streams the
// pixels out through a 4-entry FIFO over a valid/ready handshake.
//
// Optional feature: define SPRITE_TRANSPARENT_EN to drop pixels whose ROM word
// equals TRANSPARENT_KEY instead of emitting them.
module sprite_fetch_sequencer #(
   parameter int          SPRITE_W        = 32,
   parameter int          SPRITE_H        = 32,
   parameter int          NUM_FRAMES      = 3,
   parameter logic [15:0] TRANSPARENT_KEY = 16'hF81F
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        mirror,
   input  logic        advance,
   output logic        busy,
   output logic        done,
   output logic [3:0]  rom_sel,
   output logic [15:0] rom_addr,
   input  logic [15:0] rom_data,
   output logic [15:0] pixel_data,
   output logic [7:0]  pixel_x,
   output logic [7:0]  pixel_y,
   output logic        pixel_valid,
   input  logic        pixel_ready
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } state_t;

   localparam logic [7:0]  COL_LAST   = 8'(SPRITE_W - 1);
   localparam logic [7:0]  ROW_LAST   = 8'(SPRITE_H - 1);
   localparam logic [15:0] ROW_STRIDE = 16'(SPRITE_W);
   localparam logic [3:0]  FRAME_LAST = 4'(NUM_FRAMES - 1);

   state_t      state_q, state_d;
   logic [7:0]  col_q, col_d;
   logic [7:0]  row_q, row_d;
   logic        mirror_q, mirror_d;
   logic [3:0]  frame_q, frame_d;
   logic [3:0]  romSel_q, romSel_d;
   logic        pending_q, pending_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] romAddr_q, romAddr_d;

   // Tag stage 0 travels with rom_addr; stages 1 and 2 line up with rom_data.
   logic        tagV0_q, tagV1_q, tagV2_q;
   logic [7:0]  tagX0_q, tagX1_q, tagX2_q;
   logic [7:0]  tagY0_q, tagY1_q, tagY2_q;

   logic [15:0] fifoData_q [4];
   logic [7:0]  fifoX_q [4];
   logic [7:0]  fifoY_q [4];
   logic [1:0]  rdPtr_q, wrPtr_q;
   logic [2:0]  fifoCount_q;

   logic        pop;
   logic        push;
   logic        issueReq;
   logic        issue;
   logic        creditOk;
   logic        lastPixel;
   logic        mirrorEff;
   logic        drainDone;
   logic [7:0]  colPrime;
   logic [2:0]  inflight;
   logic [2:0]  outstanding;
   logic [3:0]  frameNext;

   assign pop       = (fifoCount_q != 3'd0) && pixel_ready;
   assign inflight  = {2'b00, tagV0_q} + {2'b00, tagV1_q} + {2'b00, tagV2_q};
   // A pop at this edge frees its slot in time for a read issued at the same
   // edge, which is what keeps the stream bubble-free with ready held high.
   assign outstanding = fifoCount_q + inflight - {2'b00, pop};
   assign creditOk  = outstanding < 3'd4;
   assign issueReq  = ((state_q == IDLE) && start) || (state_q == FETCH);
   assign issue     = issueReq && creditOk;
   assign lastPixel = (col_q == COL_LAST) && (row_q == ROW_LAST);
   assign mirrorEff = (state_q == IDLE) ? mirror : mirror_q;
   assign colPrime  = mirrorEff ? (COL_LAST - col_q) : col_q;
   assign drainDone = !tagV0_q && !tagV1_q && !tagV2_q
                      && (fifoCount_q == {2'b00, pop});
   assign frameNext = (frame_q == FRAME_LAST) ? 4'd0 : frame_q + 4'd1;

`ifdef SPRITE_TRANSPARENT_EN
   assign push = tagV2_q && (rom_data != TRANSPARENT_KEY);
`else
   logic unusedKey;
   assign unusedKey = ^TRANSPARENT_KEY;
   assign push = tagV2_q;
`endif

   // Next-state logic: scan counters, address generation, frame bookkeeping.
   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      mirror_d  = mirror_q;
      frame_d   = frame_q;
      romSel_d  = romSel_q;
      pending_d = pending_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      romAddr_d = romAddr_q;

      if (issue) begin
         romAddr_d = 16'(row_q) * ROW_STRIDE + 16'(colPrime);
         if (lastPixel) begin
            col_d = 8'd0;
            row_d = 8'd0;
         end else if (col_q == COL_LAST) begin
            col_d = 8'd0;
            row_d = row_q + 8'd1;
         end else begin
            col_d = col_q + 8'd1;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               romSel_d = frame_q;
               mirror_d = mirror;
               busy_d   = 1'b1;
               state_d  = lastPixel ? DRAIN : FETCH;
               if (advance) begin
                  pending_d = 1'b1;
               end
            end else if (advance) begin
               frame_d = frameNext;
            end
         end
         FETCH: begin
            if (advance) begin
               pending_d = 1'b1;
            end
            if (issue && lastPixel) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (advance) begin
               pending_d = 1'b1;
            end
            if (drainDone) begin
               state_d   = IDLE;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               pending_d = 1'b0;
               if (pending_q || advance) begin
                  frame_d = frameNext;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and address registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         col_q     <= 8'd0;
         row_q     <= 8'd0;
         mirror_q  <= 1'b0;
         frame_q   <= 4'd0;
         romSel_q  <= 4'd0;
         pending_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         romAddr_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         mirror_q  <= mirror_d;
         frame_q   <= frame_d;
         romSel_q  <= romSel_d;
         pending_q <= pending_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         romAddr_q <= romAddr_d;
      end
   end

   // Coordinate tags shadow each read until its data returns from the ROM.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tagV0_q <= 1'b0;
         tagV1_q <= 1'b0;
         tagV2_q <= 1'b0;
         tagX0_q <= 8'd0;
         tagX1_q <= 8'd0;
         tagX2_q <= 8'd0;
         tagY0_q <= 8'd0;
         tagY1_q <= 8'd0;
         tagY2_q <= 8'd0;
      end else begin
         tagV0_q <= issue;
         if (issue) begin
            tagX0_q <= colPrime;
            tagY0_q <= row_q;
         end
         tagV1_q <= tagV0_q;
         tagX1_q <= tagX0_q;
         tagY1_q <= tagY0_q;
         tagV2_q <= tagV1_q;
         tagX2_q <= tagX1_q;
         tagY2_q <= tagY1_q;
      end
   end

   // Pixel FIFO; credit accounting upstream guarantees it never overflows.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            fifoData_q[i] <= 16'd0;
            fifoX_q[i]    <= 8'd0;
            fifoY_q[i]    <= 8'd0;
         end
         rdPtr_q     <= 2'd0;
         wrPtr_q     <= 2'd0;
         fifoCount_q <= 3'd0;
      end else begin
         if (push) begin
            fifoData_q[wrPtr_q] <= rom_data;
            fifoX_q[wrPtr_q]    <= tagX2_q;
            fifoY_q[wrPtr_q]    <= tagY2_q;
            wrPtr_q             <= wrPtr_q + 2'd1;
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + 2'd1;
         end
         fifoCount_q <= fifoCount_q + {2'b00, push} - {2'b00, pop};
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign rom_sel     = romSel_q;
   assign rom_addr    = romAddr_q;
   assign pixel_data  = fifoData_q[rdPtr_q];
   assign pixel_x     = fifoX_q[rdPtr_q];
   assign pixel_y     = fifoY_q[rdPtr_q];
   assign pixel_valid = (fifoCount_q != 3'd0);

endmodule

// File: tb/tb_sprite_fetch_sequencer.sv
// Directed testbench for sprite_fetch_sequencer with a 4x4 sprite and three
// animation frames. A small ROM model returns data two edges after each
// address, and a negedge monitor records every pixel handshake.
module tb_sprite_fetch_sequencer;

   logic        clock;
   logic        reset;
   logic        start;
   logic        mirror;
   logic        advance;
   logic        busy;
   logic        done;
   logic [3:0]  rom_sel;
   logic [15:0] rom_addr;
   logic [15:0] rom_data;
   logic [15:0] pixel_data;
   logic [7:0]  pixel_x;
   logic [7:0]  pixel_y;
   logic        pixel_valid;
   logic        pixel_ready;

   int          assertCount = 0;
   int          failCount   = 0;
   logic [31:0] hsQ [$];
   logic [15:0] romPipe;
   logic [3:0]  romPipeSel;
   bit          injectKey = 1'b0;

   sprite_fetch_sequencer #(
      .SPRITE_W   (4),
      .SPRITE_H   (4),
      .NUM_FRAMES (3)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .mirror      (mirror),
      .advance     (advance),
      .busy        (busy),
      .done        (done),
      .rom_sel     (rom_sel),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .pixel_data  (pixel_data),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .pixel_valid (pixel_valid),
      .pixel_ready (pixel_ready)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // ROM contents: a recognisable word per frame and address.
   function automatic logic [15:0] romWord(input logic [3:0] sel, input logic [15:0] addr);
      if (injectKey && (addr == 16'd5 || addr == 16'd9)) begin
         return 16'hF81F;
      end
      return 16'h0100 + {sel, 12'h000} + addr;
   endfunction

   // ROM with two edges of read latency.
   always @(posedge clock) begin
      romPipe    <= rom_addr;
      romPipeSel <= rom_sel;
      rom_data   <= romWord(romPipeSel, romPipe);
   end

   // Record each handshake that the coming rising edge will complete.
   always @(negedge clock) begin
      if (!reset && pixel_valid && pixel_ready) begin
         hsQ.push_back({pixel_data, pixel_x, pixel_y});
      end
   end

   // Hard stop in case the design wedges.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic startV, input logic mirrorV, input logic advanceV);
      start   = startV;
      mirror  = mirrorV;
      advance = advanceV;
   endtask

   task automatic waitEdge();
      @(posedge clock);
      #2;
   endtask

   task automatic compareQueue(input bit mirrorFlag, input logic [3:0] sel, input bit skipKey);
      int          n;
      logic [7:0]  col;
      logic [7:0]  row;
      logic [7:0]  x;
      logic [15:0] addr;
      logic [31:0] expEntry;
      n = 0;
      checkOutput("handshakeCount", 32'(hsQ.size()), skipKey ? 32'd14 : 32'd16);
      for (int k = 0; k < 16; k++) begin
         col  = 8'(k % 4);
         row  = 8'(k / 4);
         x    = mirrorFlag ? (8'd3 - col) : col;
         addr = 16'(row) * 16'd4 + 16'(x);
         if (skipKey && (addr == 16'd5 || addr == 16'd9)) begin
            continue;
         end
         expEntry = {16'h0100 + {sel, 12'h000} + addr, x, row};
         if (n < hsQ.size()) begin
            checkOutput("pixel", hsQ[n], expEntry);
         end
         n++;
      end
   endtask

   task automatic startSprite(input logic mirrorV, input logic advanceV, input logic [3:0] expSel);
      hsQ.delete();
      applyStimulus(1'b1, mirrorV, advanceV);
      waitEdge();
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("romSel", 32'(rom_sel), 32'(expSel));
      checkOutput("busyAfterStart", 32'(busy), 32'd1);
   endtask

   task automatic waitDone();
      for (int i = 0; i < 200 && done !== 1'b1; i++) begin
         waitEdge();
      end
      checkOutput("doneSeen", 32'(done), 32'd1);
      checkOutput("busyAtDone", 32'(busy), 32'd0);
   endtask

   task automatic finishSprite(input bit mirrorFlag, input logic [3:0] sel, input bit skipKey);
      waitDone();
      compareQueue(mirrorFlag, sel, skipKey);
   endtask

   task automatic idleAdvance();
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitEdge();
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int maxOut;
      int curOut;
      reset       = 1'b1;
      pixel_ready = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Reset state
      waitEdge();
      waitEdge();
      checkOutput("resetFlags", {29'd0, busy, done, pixel_valid}, 32'd0);
      checkOutput("resetRom", {12'd0, rom_sel, rom_addr}, 32'd0);
      checkOutput("resetPixel", {pixel_data, pixel_x, pixel_y}, 32'd0);
      reset = 1'b0;
      waitEdge();

      // Basic scan with exact edge timing
      hsQ.delete();
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitEdge();
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("addrE0", 32'(rom_addr), 32'd0);
      checkOutput("busyE0", 32'(busy), 32'd1);
      for (int i = 1; i <= 22; i++) begin
         waitEdge();
         if (i == 1)  checkOutput("addrE1", 32'(rom_addr), 32'd1);
         if (i == 2)  checkOutput("validE2", 32'(pixel_valid), 32'd0);
         if (i == 3) begin
            checkOutput("validE3", 32'(pixel_valid), 32'd1);
            checkOutput("headE3", {pixel_data, pixel_x, pixel_y}, {16'h0100, 8'd0, 8'd0});
         end
         if (i == 18) begin
            checkOutput("doneE18", 32'(done), 32'd0);
            checkOutput("busyE18", 32'(busy), 32'd1);
            checkOutput("hsE18", 32'(hsQ.size()), 32'd15);
         end
         if (i == 19) begin
            checkOutput("doneE19", 32'(done), 32'd1);
            checkOutput("busyE19", 32'(busy), 32'd0);
            checkOutput("hsE19", 32'(hsQ.size()), 32'd16);
         end
         if (i == 20) checkOutput("doneE20", 32'(done), 32'd0);
      end
      compareQueue(1'b0, 4'd0, 1'b0);

      // Mirrored scan
      startSprite(1'b1, 1'b0, 4'd0);
      checkOutput("mirAddr0", 32'(rom_addr), 32'd3);
      waitEdge();
      checkOutput("mirAddr1", 32'(rom_addr), 32'd2);
      waitEdge();
      checkOutput("mirAddr2", 32'(rom_addr), 32'd1);
      finishSprite(1'b1, 4'd0, 1'b0);

      // Backpressure: ready low across edges E10..E19
      startSprite(1'b0, 1'b0, 4'd0);
      maxOut = 1;
      for (int i = 1; i <= 40 && done !== 1'b1; i++) begin
         waitEdge();
         curOut = int'(rom_addr) + 1 - hsQ.size();
         if (curOut > maxOut) maxOut = curOut;
         if (i == 9) pixel_ready = 1'b0;
         if (i == 12) begin
            checkOutput("stallAddr12", 32'(rom_addr), 32'd9);
            checkOutput("stallHead12", {pixel_data, pixel_x, pixel_y}, {16'h0106, 8'd2, 8'd1});
         end
         if (i == 19) begin
            checkOutput("stallAddr19", 32'(rom_addr), 32'd9);
            checkOutput("stallHead19", {pixel_data, pixel_x, pixel_y}, {16'h0106, 8'd2, 8'd1});
            checkOutput("stallValid19", 32'(pixel_valid), 32'd1);
            pixel_ready = 1'b1;
         end
         if (i == 28) checkOutput("bpDoneE28", 32'(done), 32'd0);
         if (i == 29) checkOutput("bpDoneE29", 32'(done), 32'd1);
      end
      pixel_ready = 1'b1;
      checkOutput("maxOutstanding", 32'(maxOut), 32'd4);
      waitDone();
      compareQueue(1'b0, 4'd0, 1'b0);

      // Frame index: two advances while busy collapse into one step
      startSprite(1'b0, 1'b0, 4'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitEdge();
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitEdge();
      waitEdge();
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitEdge();
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("selStableBusy", 32'(rom_sel), 32'd0);
      finishSprite(1'b0, 4'd0, 1'b0);

      // start with advance in the same cycle uses the old index
      startSprite(1'b0, 1'b1, 4'd1);
      finishSprite(1'b0, 4'd1, 1'b0);

      // Index is now 2; one idle advance wraps it to 0
      idleAdvance();
      startSprite(1'b0, 1'b0, 4'd0);
      finishSprite(1'b0, 4'd0, 1'b0);

      // Three idle advances come back around to 0
      idleAdvance();
      idleAdvance();
      idleAdvance();
      startSprite(1'b1, 1'b0, 4'd0);
      finishSprite(1'b1, 4'd0, 1'b0);

      // Reset mid-sprite while running frame 1
      idleAdvance();
      startSprite(1'b0, 1'b0, 4'd1);
      for (int i = 1; i <= 10; i++) begin
         waitEdge();
      end
      checkOutput("preResetHs", 32'(hsQ.size()), 32'd7);
      reset = 1'b1;
      #1;
      checkOutput("midResetFlags", {29'd0, busy, done, pixel_valid}, 32'd0);
      checkOutput("midResetRom", {12'd0, rom_sel, rom_addr}, 32'd0);
      checkOutput("midResetPixel", {pixel_data, pixel_x, pixel_y}, 32'd0);
      waitEdge();
      reset = 1'b0;
      waitEdge();
      startSprite(1'b0, 1'b0, 4'd0);
      finishSprite(1'b0, 4'd0, 1'b0);

`ifdef SPRITE_TRANSPARENT_EN
      // Transparent pixels at addresses 5 and 9 are dropped
      injectKey = 1'b1;
      startSprite(1'b0, 1'b0, 4'd0);
      finishSprite(1'b0, 4'd0, 1'b1);
      injectKey = 1'b0;
`endif

      waitEdge();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/sprite_fetch_sequencer.md
# sprite_fetch_sequencer

Upstream address generator and pixel streamer for the sprite ROM reader. On each `start` it walks every pixel of one animation frame (`SPRITE_W` × `SPRITE_H`) and drives the ROM select and address into the ROM-read stage. It re-aligns the 2-cycle-latency read data with pixel coordinates and buffers it in a small FIFO. Pixels go to the LCD writer over a valid/ready stream; the animation frame index is managed across sprites.

## Interface
Parameters:
- `SPRITE_W`, 32: sprite width in pixels, 1–256.
- `SPRITE_H`, 32: sprite height in pixels, 1–256; `SPRITE_W*SPRITE_H` ≤ 65536.
- `NUM_FRAMES`, 3: number of animation ROMs, 1–16.
- `TRANSPARENT_KEY`, 16'hF81F: RGB565 colour treated as transparent (used only with the macro).

Ports:
- `clock`  in  1  sole clock; all state is rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request a full sprite fetch; sampled only in IDLE.
- `mirror`  in  1  horizontal flip; sampled with `start`.
- `advance`  in  1  step the animation frame index.
- `busy`  out  1  high from the accepted `start` until the final pixel handshake.
- `done`  out  1  one-cycle pulse at sprite completion.
- `rom_sel`  out  4  ROM select, equal to the frame index latched at `start`.
- `rom_addr`  out  16  ROM address, registered.
- `rom_data`  in  16  read data, valid 2 edges after `rom_addr` is registered.
- `pixel_data`  out  16  RGB565 from the FIFO head.
- `pixel_x`, `pixel_y`  out  8 each  sprite-local coordinates of `pixel_data`.
- `pixel_valid`  out  1  FIFO non-empty.
- `pixel_ready`  in  1  consumer accepts; handshake = valid & ready at an edge.

## Operation
- Reset values: `busy`, `done`, and `pixel_valid` are 0. `rom_sel`, `rom_addr`, `pixel_data`, `pixel_x`, `pixel_y`, and the frame index are 0. State is IDLE.
- Reset clears the FIFO, the tag pipeline and any pending advance. Read data in flight when reset is released is discarded.
- States:
  - IDLE: on `start`, latch the frame index into `rom_sel`, latch `mirror`, set col/row = 0 and go to FETCH. `start` in any other state is ignored.
  - FETCH: issue one read per cycle when `fifo_count + inflight < 4`, otherwise hold. After the read for (`SPRITE_W`-1, `SPRITE_H`-1) is issued, go to DRAIN.
  - DRAIN: wait until the tag pipeline and the FIFO are both empty. Then pulse `done`, clear `busy` and go to IDLE.
- Address: `rom_addr` = row·`SPRITE_W` + col' (16-bit). col' = col, or `SPRITE_W`-1-col when mirrored.
- Coordinates: `pixel_x` = col' and `pixel_y` = row, so screen placement follows the mirror.
- Scan order: col increments; at `SPRITE_W`-1 it wraps to 0 and row increments.
- Tag pipeline: 2 stages carrying {valid, x, y}, aligned with `rom_data`. A valid tag at stage 2 writes {`rom_data`, x, y} into the 4-entry FIFO.
- Credit rule: the FIFO never overflows. A pop and a push in the same cycle are allowed at any occupancy.
- Frame index:
  - `advance` in IDLE: index increments, wrapping from `NUM_FRAMES`-1 to 0.
  - `advance` while busy: a single pending flag is set. Multiple pulses collapse into one step. The step is applied on the edge that returns to IDLE.
  - A sprite never mixes frames.
- `start` and `advance` in the same IDLE cycle: the sprite uses the old index, and the advance is recorded as pending.

## Timing
- `start` is sampled at edge E0; the address for pixel 0 is valid after E0.
- `rom_data` for that address is valid after E2, is written to the FIFO at E3, and `pixel_valid` rises after E3.
- With `pixel_ready` held high: one pixel per cycle, with no bubbles after the first.
- For N = `SPRITE_W`·`SPRITE_H`, the final handshake is at E(N+3). `done` is high for the single cycle after E(N+3), and `busy` falls at that same edge.
- `pixel_data`, `pixel_x` and `pixel_y` hold stable while `pixel_valid` is high and `pixel_ready` is low.

## Configuration
- `SPRITE_TRANSPARENT_EN` defined: a stage-2 tag whose `rom_data` equals `TRANSPARENT_KEY` is dropped, not written. The credit is freed, no handshake occurs for that pixel, and `done` still fires after the last issued read drains.
- Macro not defined: every pixel is emitted and `TRANSPARENT_KEY` is unused.

## Test plan
- Basic scan: W=H=4, frame 0, `pixel_ready`=1, `start` at E0 → 16 pixels with x,y in raster order (0,0)…(3,3) and data = ROM word 0…15. `done` is high only after E19.
- Mirror: `mirror`=1, W=H=4 → the first three addresses are 3,2,1 with `pixel_x` 3,2,1. Data at (3,0) equals ROM word 3.
- Backpressure: `pixel_ready` low for 10 cycles mid-sprite → `rom_addr` stalls with ≤4 outstanding. There is no loss or duplication, and exactly 16 handshakes occur in order.
- Frame wrap: NUM_FRAMES=3 with two `advance` pulses during busy → the next sprite has `rom_sel`=1. Three advances in IDLE return `rom_sel` to 0.
- Reset mid-sprite: assert `reset` at pixel 7 → all outputs are 0 immediately. A subsequent `start` yields exactly 16 fresh pixels from (0,0).
- With `SPRITE_TRANSPARENT_EN`: ROM words 5 and 9 = 16'hF81F → 14 handshakes, coordinates (1,1) and (1,2) are absent, and `done` still pulses.
